// File: rtl/eth_mac_rx_addr_filter.sv
// eth_mac_rx_addr_filter
// Receive-side destination address filter sitting behind the MAC rx AXI-stream.
// Every frame is written into a small circular byte FIFO while its first six
// bytes are collected. The reader is held at the frame start until the
// destination address has been judged. Accepted frames are released in full.
// Rejected frames and runts are removed by rewinding the write pointer.
// Optional build macro: ETH_RX_FILTER_MCAST_EN. When it is defined, group
// addresses are also accepted while cfg_mcast_en is set.
module eth_mac_rx_addr_filter #(
  parameter int FIFO_ADDR_WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  input  logic [47:0] cfg_local_mac,
  input  logic        cfg_promisc,
  input  logic        cfg_bcast_en,
  input  logic        cfg_mcast_en,
  output logic        stat_drop_addr,
  output logic        stat_drop_runt
);

  localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
  localparam int PW    = FIFO_ADDR_WIDTH + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_HDR  = 2'd1,
    W_PASS = 2'd2,
    W_DROP = 2'd3
  } wstate_t;

  wstate_t       wstate_r;
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] frame_start_ptr_r;
  logic [PW-1:0] rd_limit_s;
  logic [9:0]    mem_r [DEPTH];
  logic [7:0]    hdr_r [5];
  logic [2:0]    byte_idx_r;
  logic [47:0]   dest_s;
  logic          is_bcast_s;
  logic          accept_s;
  logic          wr_en_s;

  // Destination address: five captured header bytes plus the byte on the bus now.
  always_comb begin
    dest_s = {hdr_r[0], hdr_r[1], hdr_r[2], hdr_r[3], hdr_r[4], s_axis_tdata};
  end

  // Address acceptance rules evaluated in the decision cycle.
  always_comb begin
    is_bcast_s = (dest_s == 48'hFFFF_FFFF_FFFF);
`ifdef ETH_RX_FILTER_MCAST_EN
    accept_s = cfg_promisc | (dest_s == cfg_local_mac) |
               ((cfg_bcast_en | cfg_mcast_en) & is_bcast_s) |
               (cfg_mcast_en & dest_s[40]);
`else
    accept_s = cfg_promisc | (dest_s == cfg_local_mac) |
               (cfg_bcast_en & is_bcast_s);
`endif
  end

`ifndef ETH_RX_FILTER_MCAST_EN
  // Without the multicast build option the enable has no effect.
  logic mcast_unused_s;
  assign mcast_unused_s = cfg_mcast_en;
`endif

  // Bytes are stored unless the current frame is being discarded.
  always_comb begin
    wr_en_s = s_axis_tvalid & (wstate_r != W_DROP) & ~rst;
  end

  // FIFO storage; slots past the write pointer are simply overwritten later.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r[FIFO_ADDR_WIDTH-1:0]] <= {s_axis_tdata, s_axis_tlast, s_axis_tuser};
    end
  end

  // Writer FSM: header capture, address decision, pass/drop, runt handling.
  always_ff @(posedge clk) begin
    if (rst) begin
      wstate_r          <= W_IDLE;
      wr_ptr_r          <= '0;
      frame_start_ptr_r <= '0;
      byte_idx_r        <= 3'd0;
      stat_drop_addr    <= 1'b0;
      stat_drop_runt    <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        hdr_r[i] <= 8'd0;
      end
    end else begin
      stat_drop_addr <= 1'b0;
      stat_drop_runt <= 1'b0;
      case (wstate_r)
        W_IDLE: begin
          if (s_axis_tvalid) begin
            hdr_r[0]          <= s_axis_tdata;
            frame_start_ptr_r <= wr_ptr_r;
            byte_idx_r        <= 3'd1;
            if (s_axis_tlast) begin
              // One-byte frame: leave the pointer where it was.
              stat_drop_runt <= 1'b1;
            end else begin
              wr_ptr_r <= wr_ptr_r + PTR_ONE;
              wstate_r <= W_HDR;
            end
          end
        end
        W_HDR: begin
          if (s_axis_tvalid) begin
            if (byte_idx_r == 3'd5) begin
              if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
                wstate_r <= s_axis_tlast ? W_IDLE : W_PASS;
              end else begin
                wr_ptr_r       <= frame_start_ptr_r;
                stat_drop_addr <= 1'b1;
                wstate_r       <= s_axis_tlast ? W_IDLE : W_DROP;
              end
            end else if (s_axis_tlast) begin
              wr_ptr_r       <= frame_start_ptr_r;
              stat_drop_runt <= 1'b1;
              wstate_r       <= W_IDLE;
            end else begin
              hdr_r[byte_idx_r] <= s_axis_tdata;
              byte_idx_r        <= byte_idx_r + 3'd1;
              wr_ptr_r          <= wr_ptr_r + PTR_ONE;
            end
          end
        end
        W_PASS: begin
          if (s_axis_tvalid) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (s_axis_tlast) begin
              wstate_r <= W_IDLE;
            end
          end
        end
        W_DROP: begin
          if (s_axis_tvalid && s_axis_tlast) begin
            wstate_r <= W_IDLE;
          end
        end
        default: begin
          wstate_r <= W_IDLE;
        end
      endcase
    end
  end

  // The reader may not pass the start of a frame whose address is still undecided.
  always_comb begin
    case (wstate_r)
      W_IDLE:  rd_limit_s = wr_ptr_r;
      W_PASS:  rd_limit_s = wr_ptr_r;
      W_HDR:   rd_limit_s = frame_start_ptr_r;
      W_DROP:  rd_limit_s = frame_start_ptr_r;
      default: rd_limit_s = wr_ptr_r;
    endcase
  end

  // Reader: pop one byte per cycle into the registered output stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r      <= '0;
      m_axis_tdata  <= 8'd0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
    end else if (rd_ptr_r != rd_limit_s) begin
      {m_axis_tdata, m_axis_tlast, m_axis_tuser} <= mem_r[rd_ptr_r[FIFO_ADDR_WIDTH-1:0]];
      m_axis_tvalid <= 1'b1;
      rd_ptr_r      <= rd_ptr_r + PTR_ONE;
    end else begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_eth_mac_rx_addr_filter.sv
// Testbench for eth_mac_rx_addr_filter: directed frames from the test plan
// followed by randomized frames, all checked against a frame-level model.
module tb_eth_mac_rx_addr_filter;

  localparam int AW = 4;
`ifdef ETH_RX_FILTER_MCAST_EN
  localparam int MCAST_BUILD = 1;
`else
  localparam int MCAST_BUILD = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_tdata = 8'd0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tuser = 1'b0;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tuser;
  logic [47:0] cfg_local_mac = 48'h0200_0000_0001;
  logic        cfg_promisc = 1'b0;
  logic        cfg_bcast_en = 1'b0;
  logic        cfg_mcast_en = 1'b0;
  logic        stat_addr;
  logic        stat_runt;

  eth_mac_rx_addr_filter #(.FIFO_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .cfg_local_mac(cfg_local_mac), .cfg_promisc(cfg_promisc), .cfg_bcast_en(cfg_bcast_en),
    .cfg_mcast_en(cfg_mcast_en), .stat_drop_addr(stat_addr), .stat_drop_runt(stat_runt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  typedef logic [9:0] ent_t;     // {data, last, user}
  ent_t exp_q[$];                // bytes the DUT must still emit, in order
  ent_t hdr_q[$];                // bytes of the current frame awaiting a decision
  int   mode = 0;                // 0 collecting header, 1 forwarding, 2 discarding
  bit   exp_addr = 1'b0;
  bit   exp_runt = 1'b0;

  function automatic bit model_accept(input logic [47:0] dest);
    bit ok;
    ok = cfg_promisc || (dest == cfg_local_mac) ||
         (cfg_bcast_en && (dest == 48'hFFFF_FFFF_FFFF));
`ifdef ETH_RX_FILTER_MCAST_EN
    if (cfg_mcast_en && dest[40]) ok = 1'b1;
`endif
    return ok;
  endfunction

  initial begin : model
    ent_t e;
    logic [47:0] dest;
    forever begin
      @(posedge clk);
      exp_addr = 1'b0;
      exp_runt = 1'b0;
      if (rst) begin
        exp_q.delete();
        hdr_q.delete();
        mode = 0;
      end else if (s_tvalid) begin
        e = {s_tdata, s_tlast, s_tuser};
        if (mode == 0) begin
          hdr_q.push_back(e);
          if (hdr_q.size() == 6) begin
            for (int k = 0; k < 6; k++) dest[47-8*k -: 8] = hdr_q[k][9:2];
            if (model_accept(dest)) begin
              foreach (hdr_q[k]) exp_q.push_back(hdr_q[k]);
              mode = s_tlast ? 0 : 1;
            end else begin
              exp_addr = 1'b1;
              mode = s_tlast ? 0 : 2;
            end
            hdr_q.delete();
          end else if (s_tlast) begin
            exp_runt = 1'b1;
            hdr_q.delete();
          end
        end else if (mode == 1) begin
          exp_q.push_back(e);
          if (s_tlast) mode = 0;
        end else begin
          if (s_tlast) mode = 0;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  int out_cnt = 0, addr_cnt = 0, runt_cnt = 0, tuser_cnt = 0;
  int max_occ = 0;
  bit lat_arm = 1'b0;
  int first_out_cyc = 0;
  int start_cyc = 0;

  initial begin : compare
    ent_t e;
    logic [AW:0] occ;
    forever begin
      @(negedge clk);
      if (stat_addr === 1'b1 || exp_addr) chk("stat_drop_addr", stat_addr, exp_addr);
      if (stat_runt === 1'b1 || exp_runt) chk("stat_drop_runt", stat_runt, exp_runt);
      if (stat_addr === 1'b1) addr_cnt++;
      if (stat_runt === 1'b1) runt_cnt++;
      if (m_tvalid === 1'b1) begin
        out_cnt++;
        if (m_tlast && m_tuser) tuser_cnt++;
        if (lat_arm) begin
          first_out_cyc = cyc;
          lat_arm = 1'b0;
        end
        if (exp_q.size() == 0) begin
          chk("unexpected_output_byte", {m_tdata, m_tlast, m_tuser}, -1);
        end else begin
          e = exp_q.pop_front();
          chk("m_axis_byte", {m_tdata, m_tlast, m_tuser}, e);
        end
      end
      occ = dut.wr_ptr_r - dut.rd_ptr_r;
      if (int'(occ) > max_occ) max_occ = int'(occ);
      if (occ > 5'd7) chk("fifo_occupancy_le7", occ, 7);
    end
  end

  // ---------------- driver ----------------
  logic [47:0] pend_mac = 48'h0200_0000_0001;
  bit pend_promisc = 1'b0, pend_bcast = 1'b0, pend_mcast = 1'b0;

  task automatic put(input logic [7:0] d, input logic l, input logic u);
    @(posedge clk); #1;
    s_tdata = d; s_tvalid = 1'b1; s_tlast = l; s_tuser = u;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      s_tdata = 8'd0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    end
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1;
    rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Sends one frame; configuration changes are applied on byte 0, which is
  // never a decision byte. rst_at >= 0 resets the DUT before that byte.
  task automatic send_frame(input logic [47:0] dest, input int len, input int pace,
                            input logic user, input int rst_at);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      if (i == rst_at) begin
        pulse_rst();
        return;
      end
      b = (i < 6) ? dest[47-8*i -: 8] : 8'($urandom_range(255));
      put(b, i == len - 1, (i == len - 1) ? user : 1'b0);
      if (i == 0) begin
        start_cyc = cyc;
        cfg_local_mac = pend_mac; cfg_promisc = pend_promisc;
        cfg_bcast_en = pend_bcast; cfg_mcast_en = pend_mcast;
      end
      if (i != len - 1) idle(pace);
    end
  endtask

  int b_out, b_addr, b_runt, b_user;
  task automatic mark();
    b_out = out_cnt; b_addr = addr_cnt; b_runt = runt_cnt; b_user = tuser_cnt;
  endtask

  localparam logic [47:0] LOCAL = 48'h0200_0000_0001;
  localparam logic [47:0] OTHER = 48'h0200_0000_0002;
  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] MCAST = 48'h0100_5E00_0001;

  initial begin : main
    logic [47:0] dest;
    int len, pace, sel;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_m_tvalid", m_tvalid, 0);
    chk("reset_m_tdata", m_tdata, 0);
    chk("reset_m_tlast", m_tlast, 0);
    chk("reset_m_tuser", m_tuser, 0);
    chk("reset_stat_addr", stat_addr, 0);
    chk("reset_stat_runt", stat_runt, 0);
    @(posedge clk); #1 rst = 1'b0;
    idle(2);

    // Frame to the station address at full rate
    mark(); lat_arm = 1'b1;
    send_frame(LOCAL, 64, 0, 1'b0, -1); idle(20);
    chk("t1_out_bytes", out_cnt - b_out, 64);
    chk("t1_latency", first_out_cyc - start_cyc, 7);
    chk("t1_addr_pulses", addr_cnt - b_addr, 0);
    chk("t1_runt_pulses", runt_cnt - b_runt, 0);

    // Frame to a foreign unicast address
    mark(); send_frame(OTHER, 64, 0, 1'b0, -1); idle(20);
    chk("t2_out_bytes", out_cnt - b_out, 0);
    chk("t2_addr_pulses", addr_cnt - b_addr, 1);

    // Broadcast with the enable off, then on
    mark(); send_frame(BCAST, 60, 0, 1'b0, -1); idle(20);
    chk("t3a_out_bytes", out_cnt - b_out, 0);
    chk("t3a_addr_pulses", addr_cnt - b_addr, 1);
    pend_bcast = 1'b1;
    mark(); send_frame(BCAST, 60, 0, 1'b0, -1); idle(20);
    chk("t3b_out_bytes", out_cnt - b_out, 60);
    chk("t3b_addr_pulses", addr_cnt - b_addr, 0);
    pend_bcast = 1'b0;

    // Runt, then a good frame
    mark(); send_frame(LOCAL, 4, 0, 1'b0, -1); idle(20);
    chk("t4_runt_out", out_cnt - b_out, 0);
    chk("t4_runt_pulses", runt_cnt - b_runt, 1);
    mark(); send_frame(LOCAL, 64, 0, 1'b0, -1); idle(20);
    chk("t4_next_out", out_cnt - b_out, 64);

    // Back-to-back passing frames, errored second frame
    mark(); max_occ = 0;
    send_frame(LOCAL, 64, 0, 1'b0, -1); idle(1);
    send_frame(LOCAL, 64, 0, 1'b1, -1); idle(20);
    chk("t5_out_bytes", out_cnt - b_out, 128);
    chk("t5_tuser_last", tuser_cnt - b_user, 1);
    chk("t5_max_occ_le7", max_occ <= 7, 1);

    // 10M pacing with a reset in the middle of a passing frame
    send_frame(LOCAL, 64, 7, 1'b0, 30);
    @(negedge clk);
    chk("t6_post_rst_tvalid", m_tvalid, 0);
    chk("t6_post_rst_tdata", m_tdata, 0);
    mark(); idle(4);
    send_frame(LOCAL, 60, 7, 1'b0, -1); idle(20);
    chk("t6_next_out", out_cnt - b_out, 60);
    chk("t6_no_stats", (addr_cnt - b_addr) + (runt_cnt - b_runt), 0);

    // Multicast group address with the multicast enable set
    pend_mcast = 1'b1;
    mark(); send_frame(MCAST, 60, 7, 1'b0, -1); idle(20);
    chk("t7_mcast_out", out_cnt - b_out, MCAST_BUILD ? 60 : 0);
    chk("t7_mcast_addr_pulses", addr_cnt - b_addr, MCAST_BUILD ? 0 : 1);
    pend_mcast = 1'b0;

    // Randomized frames against the model
    pend_mac = {16'h0200, 32'($urandom)};
    for (int f = 0; f < 200; f++) begin
      pend_promisc = ($urandom_range(7) == 0);
      pend_bcast = $urandom_range(1);
      pend_mcast = $urandom_range(1);
      sel = $urandom_range(4);
      case (sel)
        0: dest = pend_mac;
        1: dest = pend_mac ^ (48'h1 << (8 * $urandom_range(5)));
        2: dest = BCAST;
        3: dest = {24'h01005E, 24'($urandom)};
        default: dest = {16'($urandom), 32'($urandom)};
      endcase
      len = ($urandom_range(5) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 70);
      pace = ($urandom_range(7) == 0) ? $urandom_range(1, 7) : 0;
      send_frame(dest, len, pace, 1'($urandom_range(1)),
                 ($urandom_range(19) == 0) ? $urandom_range(len - 1) : -1);
      idle($urandom_range(3));
    end
    idle(40);
    chk("final_queue_drained", exp_q.size(), 0);
    chk("final_max_occ_le7", max_occ <= 7, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
